// File: rtl/button_debounce_if.sv
// Button debounce bus: raw key pins and edge-clear strobes flow into the
// debouncer; the debounced level, press pulses and sticky flags flow out.
interface button_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] raw_n;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] btn_out;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] edge_capture;

  // Board/CPU side drives the pins and clear strobes.
  modport master (
    output raw_n,
    output edge_clr,
    input  btn_out,
    input  press_pulse,
    input  edge_capture
  );

  // Debouncer side.
  modport slave (
    input  raw_n,
    input  edge_clr,
    output btn_out,
    output press_pulse,
    output edge_capture
  );
endinterface

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer.
// Each active-low key pin is synchronised, then a per-channel counter
// requires DEBOUNCE_CYCLES consecutive disagreeing samples before the
// debounced level (active-high) is allowed to follow. Accepted presses give
// a one-cycle pulse.
// Optional feature, macro BTN_EDGE_CAPTURE_EN: sticky per-channel press
// flags with write-one-to-clear; without it edge_capture is constant 0.
module button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  button_debounce_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] btn_q;
  logic [WIDTH-1:0] press_q;
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [0:0]       state_q [WIDTH];

  // Two-flop synchronizer on the asynchronous key pins.
  // NOTE: reset loads 1 (key released) so a reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      // NOTE: non-blocking assignments keep the two stages as two flops.
      sync1_q <= bus.raw_n;
      sync2_q <= sync1_q;
    end
  end

  assign sample = ~sync2_q;

  // Per-channel stability counter and STABLE/COUNTING state machine;
  // the level flips and the press pulse fires on the last mismatch cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= ST_STABLE;
      end
    end else begin
      press_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        case (state_q[i])
          ST_STABLE: begin
            if (sample[i] != btn_q[i]) begin
              state_q[i] <= ST_COUNTING;
              cnt_q[i]   <= CNT_W'(1);
            end
          end
          default: begin
            if (sample[i] == btn_q[i]) begin
              // Glitch shorter than the window: drop the partial count.
              state_q[i] <= ST_STABLE;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              // NOTE: clearing here, never incrementing past CNT_LAST,
              // guarantees the counter cannot wrap.
              btn_q[i]   <= sample[i];
              press_q[i] <= sample[i];
              state_q[i] <= ST_STABLE;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.btn_out     = btn_q;
  assign bus.press_pulse = press_q;

`ifdef BTN_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] cap_q;

  // Sticky press flags: a press pulse sets, edge_clr clears, set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= '0;
    end else begin
      cap_q <= (cap_q & ~bus.edge_clr) | press_q;
    end
  end

  assign bus.edge_capture = cap_q;
`else
  assign bus.edge_capture = '0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (WIDTH 4, DEBOUNCE_CYCLES 8).
// A behavioural model tracks, per channel, how many consecutive edges the
// synchronised sample has disagreed with the accepted level.
module tb_button_debounce;
  localparam int W = 4;
  localparam int D = 8;
  localparam int LAT = D + 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  button_debounce_if #(.WIDTH(W)) bus ();

  button_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [W-1:0] raw_hist [2];
  logic [W-1:0] m_btn, m_pulse, m_cap;
  int           m_run [W];

  task automatic model_reset();
    raw_hist[0] = '1;
    raw_hist[1] = '1;
    m_btn   = '0;
    m_pulse = '0;
    m_cap   = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  // Advance one clock edge in both the DUT and the model, then settle on
  // the falling edge where outputs are sampled and inputs are changed.
  task automatic tick();
    logic [W-1:0] new_pulse;
    logic         s;
    @(posedge clk);
    new_pulse = '0;
    for (int i = 0; i < W; i++) begin
      s = ~raw_hist[1][i];
      if (s != m_btn[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          m_btn[i]     = s;
          new_pulse[i] = s;
          m_run[i]     = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
`ifdef BTN_EDGE_CAPTURE_EN
    m_cap = (m_cap & ~bus.edge_clr) | m_pulse;
`else
    m_cap = '0;
`endif
    m_pulse     = new_pulse;
    raw_hist[1] = raw_hist[0];
    raw_hist[0] = bus.raw_n;
    @(negedge clk);
  endtask

  function automatic bit differs();
    return {bus.btn_out, bus.press_pulse, bus.edge_capture} !== {m_btn, m_pulse, m_cap};
  endfunction

  task automatic test_reset();
    for (int c = 0; c < 50; c++) begin
      tick();
      n_checks++;
      if ({bus.btn_out, bus.press_pulse, bus.edge_capture} !== 12'h000 || differs()) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got btn=%b pulse=%b cap=%b, expected all 0",
                 c, bus.btn_out, bus.press_pulse, bus.edge_capture);
      end
    end
  endtask

  task automatic test_single_press();
    int rise = -1;
    int pulses = 0;
    int stray = 0;
    bus.raw_n = 4'b1110;
    for (int e = 1; e <= 30; e++) begin
      tick();
      n_checks++;
      if (differs()) begin
        n_fail++;
        $display("FAIL single_press edge %0d: got btn=%b pulse=%b, expected btn=%b pulse=%b",
                 e, bus.btn_out, bus.press_pulse, m_btn, m_pulse);
      end
      if (bus.btn_out[0] && rise < 0) rise = e;
      if (bus.press_pulse == 4'b0001) pulses++;
      else if (bus.press_pulse != 4'b0000) stray++;
    end
    n_checks++;
    if (rise != LAT || pulses != 1 || stray != 0) begin
      n_fail++;
      $display("FAIL single_press_latency: got rise=%0d pulses=%0d stray=%0d, expected %0d/1/0",
               rise, pulses, stray, LAT);
    end
    bus.raw_n = 4'b1111;
    pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_checks++;
      if (differs()) begin
        n_fail++;
        $display("FAIL single_release edge %0d: got btn=%b pulse=%b, expected btn=%b pulse=%b",
                 e, bus.btn_out, bus.press_pulse, m_btn, m_pulse);
      end
      if (bus.press_pulse != 0) pulses++;
    end
    n_checks++;
    if (bus.btn_out !== 4'b0000 || pulses != 0) begin
      n_fail++;
      $display("FAIL release_no_pulse: got btn=%b pulses=%0d, expected 0000/0", bus.btn_out, pulses);
    end
  endtask

  task automatic test_glitch();
    int seen = 0;
    int rise = -1;
    bus.raw_n = 4'b1101;
    for (int e = 1; e <= 25; e++) begin
      if (e == 6) bus.raw_n = 4'b1111;
      tick();
      n_checks++;
      if (differs()) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got btn=%b pulse=%b, expected btn=%b pulse=%b",
                 e, bus.btn_out, bus.press_pulse, m_btn, m_pulse);
      end
      if (bus.btn_out[1] || bus.press_pulse[1]) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL glitch_rejected: got %0d active cycles, expected 0", seen);
    end
    bus.raw_n = 4'b1101;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_checks++;
      if (differs()) begin
        n_fail++;
        $display("FAIL glitch_hold edge %0d: got btn=%b pulse=%b, expected btn=%b pulse=%b",
                 e, bus.btn_out, bus.press_pulse, m_btn, m_pulse);
      end
      if (bus.btn_out[1] && rise < 0) rise = e;
    end
    n_checks++;
    if (rise != LAT) begin
      n_fail++;
      $display("FAIL glitch_then_accept: got rise=%0d, expected %0d", rise, LAT);
    end
    bus.raw_n = 4'b1111;
    repeat (20) tick();
  endtask

  task automatic test_simultaneous();
    int rise [W];
    int fall [W];
    int full = 0;
    int other = 0;
    for (int i = 0; i < W; i++) begin rise[i] = -1; fall[i] = -1; end
    bus.raw_n = 4'b0000;
    for (int e = 1; e <= 25; e++) begin
      tick();
      n_checks++;
      if (differs()) begin
        n_fail++;
        $display("FAIL simul_press edge %0d: got btn=%b pulse=%b, expected btn=%b pulse=%b",
                 e, bus.btn_out, bus.press_pulse, m_btn, m_pulse);
      end
      for (int i = 0; i < W; i++) if (bus.btn_out[i] && rise[i] < 0) rise[i] = e;
      if (bus.press_pulse == 4'b1111) full++;
      else if (bus.press_pulse != 0) other++;
    end
    bus.raw_n = 4'b1111;
    for (int e = 1; e <= 25; e++) begin
      tick();
      n_checks++;
      if (differs()) begin
        n_fail++;
        $display("FAIL simul_release edge %0d: got btn=%b pulse=%b, expected btn=%b pulse=%b",
                 e, bus.btn_out, bus.press_pulse, m_btn, m_pulse);
      end
      for (int i = 0; i < W; i++) if (!bus.btn_out[i] && fall[i] < 0) fall[i] = e;
      if (bus.press_pulse != 0) other++;
    end
    for (int i = 0; i < W; i++) begin
      n_checks++;
      if (rise[i] != LAT || fall[i] != LAT) begin
        n_fail++;
        $display("FAIL simul_latency ch%0d: got rise=%0d fall=%0d, expected %0d/%0d",
                 i, rise[i], fall[i], LAT, LAT);
      end
    end
    n_checks++;
    if (full != 1 || other != 0) begin
      n_fail++;
      $display("FAIL simul_pulse: got full=%0d other=%0d, expected 1/0", full, other);
    end
  endtask

  task automatic test_reset_mid_count();
    int rise = -1;
    bus.raw_n = 4'b1011;
    // Edges 3..7 are the first five mismatch cycles.
    repeat (7) tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.btn_out, bus.press_pulse, bus.edge_capture} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_async: got btn=%b pulse=%b cap=%b, expected all 0",
               bus.btn_out, bus.press_pulse, bus.edge_capture);
    end
    model_reset();
    #2;
    reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_checks++;
      if (differs()) begin
        n_fail++;
        $display("FAIL reset_mid edge %0d: got btn=%b pulse=%b, expected btn=%b pulse=%b",
                 e, bus.btn_out, bus.press_pulse, m_btn, m_pulse);
      end
      if (bus.btn_out[2] && rise < 0) rise = e;
    end
    n_checks++;
    if (rise != LAT) begin
      n_fail++;
      $display("FAIL reset_mid_latency: got rise=%0d, expected %0d", rise, LAT);
    end
    bus.raw_n = 4'b1111;
    repeat (20) tick();
  endtask

`ifdef BTN_EDGE_CAPTURE_EN
  task automatic test_edge_capture();
    bus.raw_n = 4'b0111;
    repeat (LAT + 1) tick();
    n_checks++;
    if (bus.edge_capture !== 4'b1000 || differs()) begin
      n_fail++;
      $display("FAIL capture_set: got cap=%b, expected 1000", bus.edge_capture);
    end
    bus.raw_n = 4'b1111;
    repeat (LAT + 5) tick();
    bus.raw_n = 4'b0111;
    repeat (LAT) tick();
    n_checks++;
    if (bus.press_pulse !== 4'b1000) begin
      n_fail++;
      $display("FAIL capture_repress_pulse: got pulse=%b, expected 1000", bus.press_pulse);
    end
    bus.edge_clr = 4'b1000;
    tick();
    bus.edge_clr = 4'b0000;
    n_checks++;
    if (bus.edge_capture !== 4'b1000 || differs()) begin
      n_fail++;
      $display("FAIL capture_set_wins: got cap=%b, expected 1000", bus.edge_capture);
    end
    repeat (3) tick();
    bus.edge_clr = 4'b1000;
    tick();
    bus.edge_clr = 4'b0000;
    n_checks++;
    if (bus.edge_capture !== 4'b0000 || differs()) begin
      n_fail++;
      $display("FAIL capture_clear: got cap=%b, expected 0000", bus.edge_capture);
    end
    bus.raw_n = 4'b1111;
    repeat (LAT + 5) tick();
  endtask
`else
  task automatic test_edge_capture();
    int seen = 0;
    bus.edge_clr = 4'b1111;
    bus.raw_n = 4'b0111;
    repeat (LAT + 4) begin
      tick();
      if (bus.edge_capture !== 4'b0000) seen++;
    end
    bus.edge_clr = 4'b0000;
    n_checks++;
    if (seen != 0 || bus.btn_out !== 4'b1000) begin
      n_fail++;
      $display("FAIL capture_disabled: got nonzero cap cycles=%0d btn=%b, expected 0/1000",
               seen, bus.btn_out);
    end
    bus.raw_n = 4'b1111;
    repeat (LAT + 5) tick();
  endtask
`endif

  task automatic test_random();
    logic [W-1:0] r;
    for (int c = 0; c < 1500; c++) begin
      r = bus.raw_n;
      for (int i = 0; i < W; i++) if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      bus.raw_n    = r;
      bus.edge_clr = W'($urandom) & W'($urandom) & W'($urandom);
      tick();
      n_checks++;
      if (differs()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got btn=%b pulse=%b cap=%b, expected btn=%b pulse=%b cap=%b",
                 c, bus.btn_out, bus.press_pulse, bus.edge_capture, m_btn, m_pulse, m_cap);
      end
    end
    bus.edge_clr = '0;
    bus.raw_n    = '1;
    repeat (LAT + 5) tick();
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.raw_n    = '1;
    bus.edge_clr = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_edge_capture();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), consecutive stable cycles required to accept a new level; legal range 2 to 2^24.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port raw_n, input, WIDTH, raw KEY pins, active-low (0 = pressed), asynchronous to clk.
REQ-006 The block SHALL have port btn_out, output, WIDTH, debounced level, active-high (1 = pressed); drives the push-button PIO in_port.
REQ-007 The block SHALL have port press_pulse, output, WIDTH, one-cycle pulse per accepted press.
REQ-008 The block SHALL have port edge_clr, input, WIDTH, write-one-to-clear strobe for edge_capture.
REQ-009 The block SHALL have port edge_capture, output, WIDTH, sticky per-channel press flags.

Function
REQ-010 Each channel SHALL pass raw_n through a two-flop synchronizer; the inverted second-stage output is the channel's sample s.
REQ-011 Each channel SHALL hold a counter of ceil(log2(DEBOUNCE_CYCLES)) bits and a two-state machine: STABLE (s == btn_out) and COUNTING (s != btn_out).
REQ-012 In STABLE, the counter SHALL be 0; the first cycle with s != btn_out SHALL move the channel to COUNTING with counter 1.
REQ-013 In COUNTING, each further mismatch cycle SHALL increment the counter; any cycle with s == btn_out SHALL return the channel to STABLE with counter 0 (glitch rejected, btn_out unchanged).
REQ-014 On the DEBOUNCE_CYCLES-th consecutive mismatch cycle, btn_out SHALL toggle at that clock edge, the counter SHALL clear to 0, and the channel SHALL return to STABLE; the counter SHALL never wrap.
REQ-015 Latency SHALL be exactly 2 + DEBOUNCE_CYCLES rising edges from a clean raw_n transition (set up before edge 0) to the btn_out change.
REQ-016 press_pulse[i] SHALL be a registered output, high for exactly the one cycle in which btn_out[i] first reads 1 after a 0->1 transition; releases SHALL produce no pulse.
REQ-017 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be debounced and pulsed in the same cycle.
REQ-018 All outputs SHALL be registered; no combinational path from raw_n or edge_clr to any output.

Reset
REQ-019 On reset_n low, synchronizer flops SHALL load 1 (released), counters 0, state STABLE, btn_out 0, press_pulse 0, edge_capture 0, asynchronously.
REQ-020 Reset asserted mid-count SHALL discard the partial count; after release, a held button SHALL require the full 2 + DEBOUNCE_CYCLES edges before btn_out rises.

Configuration
REQ-021 With macro BTN_EDGE_CAPTURE_EN defined, edge_capture[i] SHALL set on the cycle press_pulse[i] is high and clear on the cycle after edge_clr[i] is sampled high; set SHALL win over a simultaneous clear.
REQ-022 Without BTN_EDGE_CAPTURE_EN, edge_capture SHALL be tied to 0, edge_clr SHALL be ignored, and no capture flops SHALL be synthesized.

Verification (DEBOUNCE_CYCLES = 8, WIDTH = 4)
REQ-023 Reset, raw_n = 4'b1111 held -> btn_out = 0, press_pulse = 0, edge_capture = 0 for 50 cycles.
REQ-024 raw_n[0] 1->0 held -> btn_out[0] rises exactly 10 edges later, press_pulse = 4'b0001 for one cycle, other bits stay 0.
REQ-025 raw_n[1] low for 5 cycles, then high -> btn_out[1] never rises, no pulse; then low for 8+ cycles -> accepted at edge 10.
REQ-026 raw_n = 4'b0000 simultaneously, later release -> all four btn_out bits rise on the same edge, press_pulse = 4'b1111 once; release yields no pulse, btn_out = 0 after 10 edges.
REQ-027 reset_n pulsed low at count 5 with raw_n[2] held low -> btn_out[2] = 0 immediately, rises 10 edges after reset release.
REQ-028 (BTN_EDGE_CAPTURE_EN) press on channel 3 -> edge_capture = 4'b1000; edge_clr = 4'b1000 in the same cycle as a new press_pulse[3] -> edge_capture[3] stays 1; later lone edge_clr -> 0.
